fir_coeff_loader: RTL and testbench
===================================

Name: fir_coeff_loader

Overview:
- AHB-Lite single-master initiator that programs the FIR filter's coefficient memory and control register over the filter's AHB control slave port.
- Accepts a coefficient stream from a host-side AXI-Stream source (e.g. a UART or debug bridge).
- Issues one halfword write per coefficient, then a final word write to the control register that sets rate = tap count and enable = 1.
- Reports busy, done and error status to the system controller.

Parameters:
- DW, 16, coefficient width (Q15); must be ≤ 16.
- COEFF_BASE, 32'h0000_0000, AHB byte address of coefficient 0; coefficient i is written at COEFF_BASE + 2*i.
- CTRL_ADDR, 32'h0000_0800, AHB byte address of the filter control register.
- MAX_TAPS, 1024, maximum number of coefficients per load.
- CW, 11, width of the tap counter; must satisfy 2^CW > MAX_TAPS.

Ports:
- clk  in  1  system clock (also HCLK)
- reset_n  in  1  asynchronous active-low reset (also HRESETn)
- start  in  1  single-cycle pulse that begins a load; ignored while busy
- busy  out  1  high from the cycle after an accepted start until the cycle done or error is set
- done  out  1  one-cycle pulse after a successful control-register write
- error  out  1  sticky flag for an AHB ERROR response; cleared by the next accepted start
- count  out  CW  number of coefficients written in the current or last load
- tdata_s  in  DW  coefficient value
- tvalid_s  in  1  AXI-Stream valid
- tlast_s  in  1  marks the last coefficient
- tready_s  out  1  AXI-Stream ready
- haddr_m  out  32  AHB address
- hburst_m  out  3  fixed 3'b000 (SINGLE)
- hsize_m  out  3  3'b001 for coefficient writes, 3'b010 for the control-register write
- htrans_m  out  2  2'b00 (IDLE) or 2'b10 (NONSEQ)
- hwdata_m  out  32  AHB write data
- hwrite_m  out  1  high during NONSEQ address phases
- hrdata_m  in  32  unused; present for bus completeness
- hready_m  in  1  HREADY from the slave/mux
- hresp_m  in  1  HRESP (1 = ERROR)

Behaviour:
- Reset values (asynchronous, all outputs registered): htrans_m = 0, haddr_m = 0, hwdata_m = 0, hwrite_m = 0, hsize_m = 3'b001, hburst_m = 0, tready_s = 0, busy = 0, done = 0, error = 0, count = 0. FSM returns to IDLE.
- Reset mid-transfer: htrans_m is IDLE immediately; no partial write is resumed afterwards.
- FSM states: IDLE, LOAD, C_ADDR, C_DATA, R_ADDR, R_DATA, DONE, ERR.
- IDLE:
  - start = 1: clear count and error, set busy, go to LOAD.
- LOAD:
  - tready_s = 1.
  - On tvalid_s && tready_s: latch tdata_s (zero-extended to 16 bits) and tlast_s, drop tready_s, go to C_ADDR.
  - Exactly one beat is accepted per coefficient.
- C_ADDR:
  - htrans_m = NONSEQ, hwrite_m = 1, hsize_m = 3'b001, haddr_m = COEFF_BASE + {count, 1'b0}.
  - Advance to C_DATA only in a cycle with hready_m = 1; otherwise hold all address-phase signals stable.
- C_DATA:
  - htrans_m = IDLE; hwdata_m = {16'h0, coeff}, held until hready_m = 1.
  - On hready_m && !hresp_m: count increments. If the latched tlast is set or the new count == MAX_TAPS, go to R_ADDR; else go to LOAD.
- R_ADDR:
  - Same as C_ADDR except haddr_m = CTRL_ADDR and hsize_m = 3'b010.
- R_DATA:
  - hwdata_m = {count[15:0] (zero-extended), 15'h0, 1'b1}, i.e. rate = count and enable = 1.
  - On hready_m && !hresp_m: go to DONE.
- DONE:
  - done = 1 for one cycle, busy = 0, back to IDLE.
- Error handling:
  - hresp_m = 1 in any data phase (first or second cycle of the ERROR response): go to ERR.
  - htrans_m stays IDLE; no further transfers are issued.
  - ERR sets error = 1 and busy = 0, then goes to IDLE.
  - count retains the number of successful coefficient writes.
- Minimum cost per coefficient: 3 cycles (LOAD, C_ADDR, C_DATA) with zero wait states. No pipelining of transfers.
- Early tlast: a load of N < MAX_TAPS coefficients is legal. N = 1 is legal.
- Stream overrun: at MAX_TAPS coefficients without tlast, the load ends normally; further beats are not accepted (tready_s stays 0 until the next LOAD).
- start asserted while busy: ignored, no effect.
- Concurrent tvalid_s and start in IDLE: no beat is accepted until LOAD.

Test Plan:
- Load 16 coefficients 0x0001..0x0010 with tlast on the 16th, hready_m tied high → 17 NONSEQ transfers: halfwords at 0x000..0x01E with the matching data, then word 0x0010_0001 at 0x800; done pulses once; count = 16.
- Same load with hready_m low for 2 cycles in every data phase and tvalid_s gaps of 3 cycles → identical bus writes, with address and data held stable during waits.
- Slave returns ERROR on the 5th coefficient data phase → error = 1, busy = 0, count = 4, no control-register write, and no further NONSEQ until the next start.
- Stream 1030 beats with no tlast → exactly 1024 coefficient writes, then control data 0x0400_0001; beats 1025 onward are not accepted.
- Pulse start during a load, and assert reset_n low mid C_ADDR → the start has no effect; after reset, htrans_m = 0, busy = 0, and a new start runs a clean load from address COEFF_BASE.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - AHB-Lite initiator that loads FIR coefficients from a stream
// One halfword write per coefficient, then a word write of {rate, enable} to the control register.
module fir_coeff_loader #(
  parameter int          DW         = 16,
  parameter logic [31:0] COEFF_BASE = 32'h0000_0000,
  parameter logic [31:0] CTRL_ADDR  = 32'h0000_0800,
  parameter int          MAX_TAPS   = 1024,
  parameter int          CW         = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] count,
  input  logic [DW-1:0] tdata_s,
  input  logic          tvalid_s,
  input  logic          tlast_s,
  output logic          tready_s,
  output logic [31:0]   haddr_m,
  output logic [2:0]    hburst_m,
  output logic [2:0]    hsize_m,
  output logic [1:0]    htrans_m,
  output logic [31:0]   hwdata_m,
  output logic          hwrite_m,
  input  logic [31:0]   hrdata_m,
  input  logic          hready_m,
  input  logic          hresp_m
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_C_ADDR, S_C_DATA, S_R_ADDR, S_R_DATA, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]    HSIZE_HALF    = 3'b001;
  localparam logic [2:0]    HSIZE_WORD    = 3'b010;
  localparam logic [CW-1:0] LAST_COUNT    = CW'(MAX_TAPS);

  state_t        state_q, state_d;
  logic [15:0]   coeff_q, coeff_d;
  logic          last_q, last_d;
  logic [CW-1:0] count_d;
  logic          error_d;
  logic          busy_d;
  logic          done_d;
  logic          tready_d;
  logic [1:0]    htrans_d;
  logic          hwrite_d;
  logic [2:0]    hsize_d;
  logic [31:0]   haddr_d;
  logic [31:0]   hwdata_d;
  logic          unused_hrdata;

  assign unused_hrdata = ^hrdata_m;
  assign hburst_m      = 3'b000;

  always_comb begin
    state_d = state_q;
    coeff_d = coeff_q;
    last_d  = last_q;
    count_d = count;
    error_d = error;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d = '0;
          error_d = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (tvalid_s && tready_s) begin
          coeff_d = 16'(tdata_s);
          last_d  = tlast_s;
          state_d = S_C_ADDR;
        end
      end
      S_C_ADDR: begin
        if (hready_m) state_d = S_C_DATA;
      end
      S_C_DATA: begin
        // ERROR aborts on its first cycle, before the slave raises hready
        if (hresp_m) begin
          state_d = S_ERR;
        end else if (hready_m) begin
          count_d = count + CW'(1);
          state_d = (last_q || count_d == LAST_COUNT) ? S_R_ADDR : S_LOAD;
        end
      end
      S_R_ADDR: begin
        if (hready_m) state_d = S_R_DATA;
      end
      S_R_DATA: begin
        if (hresp_m)       state_d = S_ERR;
        else if (hready_m) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERR) error_d = 1'b1;

    // Outputs are registered, so they are derived from the state being entered
    busy_d   = !(state_d inside {S_IDLE, S_DONE, S_ERR});
    done_d   = (state_d == S_DONE);
    tready_d = (state_d == S_LOAD);
    htrans_d = (state_d inside {S_C_ADDR, S_R_ADDR}) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hwrite_d = (state_d inside {S_C_ADDR, S_R_ADDR});
    hsize_d  = (state_d inside {S_R_ADDR, S_R_DATA}) ? HSIZE_WORD : HSIZE_HALF;

    haddr_d = haddr_m;
    if (state_d == S_C_ADDR)      haddr_d = COEFF_BASE + 32'({count_d, 1'b0});
    else if (state_d == S_R_ADDR) haddr_d = CTRL_ADDR;

    hwdata_d = hwdata_m;
    if (state_d == S_C_DATA)      hwdata_d = {16'h0000, coeff_d};
    else if (state_d == S_R_DATA) hwdata_d = {16'(count_d), 15'h0000, 1'b1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      coeff_q  <= '0;
      last_q   <= 1'b0;
      count    <= '0;
      error    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tready_s <= 1'b0;
      htrans_m <= HTRANS_IDLE;
      hwrite_m <= 1'b0;
      hsize_m  <= HSIZE_HALF;
      haddr_m  <= '0;
      hwdata_m <= '0;
    end else begin
      state_q  <= state_d;
      coeff_q  <= coeff_d;
      last_q   <= last_d;
      count    <= count_d;
      error    <= error_d;
      busy     <= busy_d;
      done     <= done_d;
      tready_s <= tready_d;
      htrans_m <= htrans_d;
      hwrite_m <= hwrite_d;
      hsize_m  <= hsize_d;
      haddr_m  <= haddr_d;
      hwdata_m <= hwdata_d;
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb/tb_fir_coeff_loader.sv - directed bench for fir_coeff_loader
module tb_fir_coeff_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [10:0] count;
    logic [15:0] tdata_s = '0;
    logic        tvalid_s = 1'b0;
    logic        tlast_s = 1'b0;
    logic        tready_s;
    logic [31:0] haddr_m;
    logic [2:0]  hburst_m;
    logic [2:0]  hsize_m;
    logic [1:0]  htrans_m;
    logic [31:0] hwdata_m;
    logic        hwrite_m;
    logic [31:0] hrdata_m = 32'h0;
    logic        hready_m = 1'b1;
    logic        hresp_m = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    fir_coeff_loader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .error(error), .count(count), .tdata_s(tdata_s), .tvalid_s(tvalid_s),
        .tlast_s(tlast_s), .tready_s(tready_s), .haddr_m(haddr_m), .hburst_m(hburst_m),
        .hsize_m(hsize_m), .htrans_m(htrans_m), .hwdata_m(hwdata_m), .hwrite_m(hwrite_m),
        .hrdata_m(hrdata_m), .hready_m(hready_m), .hresp_m(hresp_m)
    );

    always #5 clk = ~clk;

    int ws = 0;
    int aws = 0;
    int err_at = -1;

    logic [31:0] addr_q[$];
    logic [2:0]  size_q[$];
    logic        wr_q[$];
    logic [31:0] data_q[$];
    int xfer_n = 0, done_cnt = 0, stab_viol = 0, dwait_cnt = 0, await_cnt = 0;
    bit in_data = 0, pend = 0, err_now = 0, ecyc = 0, aw_done = 0;
    bit prev_aw = 0, prev_dw = 0;
    int wcnt = 0;
    logic [31:0] p_addr, p_data;
    logic [2:0]  p_size;

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_bad++;
        $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            in_data = 0; pend = 0; aw_done = 0; prev_aw = 0; prev_dw = 0;
            hready_m = 1'b1; hresp_m = 1'b0;
        end else begin
            if (prev_aw && (htrans_m !== 2'b10 || haddr_m !== p_addr || hsize_m !== p_size || hwrite_m !== 1'b1))
                stab_viol++;
            if (prev_dw && hwdata_m !== p_data) stab_viol++;
            prev_aw = 0; prev_dw = 0;
            if (done === 1'b1) done_cnt++;
            if (pend) begin
                in_data = 1; pend = 0; wcnt = ws; ecyc = 0;
                err_now = (xfer_n - 1 == err_at);
            end
            if (in_data) begin
                if (err_now) begin
                    hresp_m = 1'b1;
                    if (!ecyc) begin hready_m = 1'b0; ecyc = 1; end
                    else begin hready_m = 1'b1; in_data = 0; end
                end else if (wcnt > 0) begin
                    hready_m = 1'b0; hresp_m = 1'b0; wcnt--;
                    prev_dw = 1; p_data = hwdata_m; dwait_cnt++;
                end else begin
                    hready_m = 1'b1; hresp_m = 1'b0; in_data = 0;
                    data_q.push_back(hwdata_m);
                end
            end else begin
                hresp_m = 1'b0;
                if (htrans_m === 2'b10) begin
                    if (aws > 0 && !aw_done) begin
                        hready_m = 1'b0; aw_done = 1; await_cnt++;
                        prev_aw = 1; p_addr = haddr_m; p_size = hsize_m;
                    end else begin
                        hready_m = 1'b1; aw_done = 0; pend = 1; xfer_n++;
                        addr_q.push_back(haddr_m); size_q.push_back(hsize_m); wr_q.push_back(hwrite_m);
                    end
                end else begin
                    hready_m = 1'b1;
                end
            end
        end
    end

    int a_base, d_base, done_base, sv_base, x_base, dw_base, aw_base;

    task automatic mark();
        a_base = addr_q.size(); d_base = data_q.size(); done_base = done_cnt;
        sv_base = stab_viol; x_base = xfer_n; dw_base = dwait_cnt; aw_base = await_cnt;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_beats(input int n, input int gap, input bit last_on_final,
                              input int budget, output int accepted);
        accepted = 0;
        for (int i = 0; i < n; i++) begin
            tdata_s = 16'(i + 1); tlast_s = last_on_final && (i == n - 1); tvalid_s = 1'b1;
            for (int w = 0; w < budget && tready_s !== 1'b1; w++) @(negedge clk);
            if (tready_s !== 1'b1) begin
                tvalid_s = 1'b0; tlast_s = 1'b0;
                return;
            end
            @(posedge clk);
            accepted++;
            @(negedge clk);
            tvalid_s = 1'b0; tlast_s = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int w = 0; w < budget && busy !== 1'b0; w++) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) fail("idle_timeout_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_log(input int n);
        n_cmp++; if (addr_q.size() - a_base !== n + 1) fail("n_addr", addr_q.size() - a_base, n + 1);
        n_cmp++; if (data_q.size() - d_base !== n + 1) fail("n_data", data_q.size() - d_base, n + 1);
        if (addr_q.size() - a_base == n + 1 && data_q.size() - d_base == n + 1) begin
            for (int i = 0; i < n; i++) begin
                n_cmp++; if (addr_q[a_base + i] !== 32'(2 * i)) fail("coeff_addr", addr_q[a_base + i], 32'(2 * i));
                n_cmp++; if (size_q[a_base + i] !== 3'b001) fail("coeff_size", size_q[a_base + i], 3'b001);
                n_cmp++; if (wr_q[a_base + i] !== 1'b1) fail("coeff_hwrite", wr_q[a_base + i], 1'b1);
                n_cmp++; if (data_q[d_base + i] !== 32'(i + 1)) fail("coeff_data", data_q[d_base + i], 32'(i + 1));
            end
            n_cmp++; if (addr_q[a_base + n] !== 32'h0000_0800) fail("ctrl_addr", addr_q[a_base + n], 32'h0000_0800);
            n_cmp++; if (size_q[a_base + n] !== 3'b010) fail("ctrl_size", size_q[a_base + n], 3'b010);
            n_cmp++; if (data_q[d_base + n] !== {16'(n), 16'h0001}) fail("ctrl_data", data_q[d_base + n], {16'(n), 16'h0001});
        end
        n_cmp++; if (done_cnt - done_base !== 1) fail("done_pulses", done_cnt - done_base, 1);
        n_cmp++; if (count !== 11'(n)) fail("count_final", count, 11'(n));
        n_cmp++; if (busy !== 1'b0) fail("busy_final", busy, 1'b0);
        n_cmp++; if (error !== 1'b0) fail("error_final", error, 1'b0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        #12;
        n_cmp++; if (htrans_m !== 2'b00) fail("rst_htrans", htrans_m, 2'b00);
        n_cmp++; if (haddr_m !== 32'h0) fail("rst_haddr", haddr_m, 32'h0);
        n_cmp++; if (hwdata_m !== 32'h0) fail("rst_hwdata", hwdata_m, 32'h0);
        n_cmp++; if (hwrite_m !== 1'b0) fail("rst_hwrite", hwrite_m, 1'b0);
        n_cmp++; if (hsize_m !== 3'b001) fail("rst_hsize", hsize_m, 3'b001);
        n_cmp++; if (hburst_m !== 3'b000) fail("rst_hburst", hburst_m, 3'b000);
        n_cmp++; if (tready_s !== 1'b0) fail("rst_tready", tready_s, 1'b0);
        n_cmp++; if (busy !== 1'b0) fail("rst_busy", busy, 1'b0);
        n_cmp++; if (done !== 1'b0) fail("rst_done", done, 1'b0);
        n_cmp++; if (error !== 1'b0) fail("rst_error", error, 1'b0);
        n_cmp++; if (count !== 11'h0) fail("rst_count", count, 11'h0);
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);

        mark();
        pulse_start();
        n_cmp++; if (busy !== 1'b1) fail("t1_busy_after_start", busy, 1'b1);
        send_beats(16, 0, 1'b1, 50, acc);
        n_cmp++; if (acc !== 16) fail("t1_accepted", acc, 16);
        wait_idle(100);
        check_log(16);

        ws = 2; aws = 1;
        mark();
        pulse_start();
        send_beats(16, 3, 1'b1, 50, acc);
        n_cmp++; if (acc !== 16) fail("t2_accepted", acc, 16);
        wait_idle(200);
        check_log(16);
        n_cmp++; if (stab_viol - sv_base !== 0) fail("t2_stable_violations", stab_viol - sv_base, 0);
        n_cmp++; if (dwait_cnt - dw_base !== 34) fail("t2_data_wait_cycles", dwait_cnt - dw_base, 34);
        n_cmp++; if (await_cnt - aw_base !== 17) fail("t2_addr_wait_cycles", await_cnt - aw_base, 17);
        ws = 0; aws = 0;

        mark();
        err_at = xfer_n + 4;
        pulse_start();
        send_beats(16, 0, 1'b1, 30, acc);
        err_at = -1;
        wait_idle(100);
        n_cmp++; if (acc !== 5) fail("t3_accepted", acc, 5);
        n_cmp++; if (error !== 1'b1) fail("t3_error", error, 1'b1);
        n_cmp++; if (busy !== 1'b0) fail("t3_busy", busy, 1'b0);
        n_cmp++; if (count !== 11'd4) fail("t3_count", count, 11'd4);
        n_cmp++; if (xfer_n - x_base !== 5) fail("t3_nonseq", xfer_n - x_base, 5);
        n_cmp++; if (data_q.size() - d_base !== 4) fail("t3_data_ok", data_q.size() - d_base, 4);
        n_cmp++; if (done_cnt - done_base !== 0) fail("t3_done", done_cnt - done_base, 0);
        repeat (20) @(negedge clk);
        n_cmp++; if (xfer_n - x_base !== 5) fail("t3_nonseq_later", xfer_n - x_base, 5);
        n_cmp++; if (error !== 1'b1) fail("t3_error_sticky", error, 1'b1);

        mark();
        pulse_start();
        n_cmp++; if (error !== 1'b0) fail("t4_error_cleared", error, 1'b0);
        send_beats(1030, 0, 1'b0, 40, acc);
        n_cmp++; if (acc !== 1024) fail("t4_accepted", acc, 1024);
        wait_idle(100);
        check_log(1024);
        n_cmp++; if (tready_s !== 1'b0) fail("t4_tready_after", tready_s, 1'b0);

        mark();
        pulse_start();
        send_beats(2, 0, 1'b0, 50, acc);
        n_cmp++; if (acc !== 2) fail("t5_accepted", acc, 2);
        repeat (2) @(negedge clk);
        n_cmp++; if (count !== 11'd2) fail("t5_count_before", count, 11'd2);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_cmp++; if (busy !== 1'b1) fail("t5_busy_after_restart", busy, 1'b1);
        n_cmp++; if (count !== 11'd2) fail("t5_count_kept", count, 11'd2);
        tdata_s = 16'h0003; tvalid_s = 1'b1;
        @(negedge clk); tvalid_s = 1'b0;
        n_cmp++; if (htrans_m !== 2'b10) fail("t5_in_caddr", htrans_m, 2'b10);
        n_cmp++; if (haddr_m !== 32'h0000_0004) fail("t5_caddr_addr", haddr_m, 32'h0000_0004);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (htrans_m !== 2'b00) fail("t5_rst_htrans", htrans_m, 2'b00);
        n_cmp++; if (busy !== 1'b0) fail("t5_rst_busy", busy, 1'b0);
        n_cmp++; if (count !== 11'h0) fail("t5_rst_count", count, 11'h0);
        n_cmp++; if (tready_s !== 1'b0) fail("t5_rst_tready", tready_s, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (htrans_m !== 2'b00) fail("t5_idle_after_rst", htrans_m, 2'b00);
        mark();
        pulse_start();
        send_beats(2, 0, 1'b1, 50, acc);
        n_cmp++; if (acc !== 2) fail("t5_clean_accepted", acc, 2);
        wait_idle(100);
        check_log(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
